// File: rtl/pipe_delay_line.sv
// Fixed-depth register delay line with a selectable output tap and per-stage valid bits.
// Optional occupancy counter (vld_cnt/full) is built only when PIPE_DELAY_LINE_CNT_EN is defined.
module pipe_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    input  logic                       din_vld,
    input  logic [SEL_W-1:0]           dly_sel,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_vld,
    output logic [$clog2(DEPTH+1)-1:0] vld_cnt,
    output logic                       full
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [SEL_W-1:0] tap_idx;

    // NOTE: every signal gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_d[k] = '0;
            end
            vld_d = '0;
        end else if (en) begin
            data_d[0] = din;
            vld_d[0]  = din_vld;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
                vld_d[k]  = vld_q[k-1];
            end
        end
    end

    // NOTE: the data registers are cleared on reset (not only the valid bits) because dout must read 0 after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
            vld_q <= '0;
        end else begin
            // NOTE: non-blocking updates make every stage read its neighbour's old value, so a sample moves one stage per edge.
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    // Tap selects beyond the last stage clamp to the oldest stage.
    always_comb begin
        tap_idx = dly_sel;
        if (dly_sel > SEL_W'(DEPTH - 1)) begin
            tap_idx = SEL_W'(DEPTH - 1);
        end
    end

    assign dout     = data_q[tap_idx];
    assign dout_vld = vld_q[tap_idx];

`ifdef PIPE_DELAY_LINE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (en) begin
            if (din_vld && !vld_q[DEPTH-1] && (cnt_q != CNT_W'(DEPTH))) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!din_vld && vld_q[DEPTH-1] && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign vld_cnt = cnt_q;
    assign full    = (cnt_q == CNT_W'(DEPTH));
`else
    assign vld_cnt = '0;
    assign full    = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_delay_line.sv
// Self-checking bench for pipe_delay_line: directed scenarios followed by random traffic,
// checked against a sample-history queue model.
module tb_pipe_delay_line;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef PIPE_DELAY_LINE_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             din_vld = 1'b0;
    logic [SEL_W-1:0] dly_sel = '0;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [CNT_W-1:0] vld_cnt;
    logic             full;

    int total = 0;
    int bad = 0;

    pipe_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .din(din), .din_vld(din_vld),
        .dly_sel(dly_sel), .dout(dout), .dout_vld(dout_vld), .vld_cnt(vld_cnt), .full(full)
    );

    always #5 clk = ~clk;

    // Model: most recent advance at index 0; a cleared line holds DEPTH zero samples.
    typedef struct packed { logic [WIDTH-1:0] d; logic v; } samp_t;
    samp_t hist[$];

    function automatic void m_clear();
        hist.delete();
        for (int i = 0; i < DEPTH; i++) hist.push_back('0);
    endfunction

    function automatic void m_advance(input logic [WIDTH-1:0] d, input logic v);
        samp_t s;
        s.d = d;
        s.v = v;
        hist.push_front(s);
        void'(hist.pop_back());
    endfunction

    function automatic int m_count();
        int c = 0;
        foreach (hist[i]) c += int'(hist[i].v);
        return CNT_ON ? c : 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int idx;
        idx = (int'(dly_sel) > DEPTH - 1) ? DEPTH - 1 : int'(dly_sel);
        check({tag, ".dout"}, 32'(dout), 32'(hist[idx].d));
        check({tag, ".dout_vld"}, 32'(dout_vld), 32'(hist[idx].v));
        check({tag, ".vld_cnt"}, 32'(vld_cnt), 32'(m_count()));
        check({tag, ".full"}, 32'(full), 32'(m_count() == DEPTH));
    endtask

    // Check outputs from the previous edge, then clock once and update the model.
    task automatic step(input string tag, input logic e, input logic f,
                        input logic [WIDTH-1:0] d, input logic v, input logic [SEL_W-1:0] s);
        en = e;
        flush = f;
        din = d;
        din_vld = v;
        dly_sel = s;
        #1;
        check_model(tag);
        @(posedge clk);
        if (!rst_n || f) m_clear();
        else if (e) m_advance(d, v);
        #1;
    endtask

    initial begin
        int fill_cnt[6];
        int drain_cnt[4];
        fill_cnt = '{1, 2, 3, 4, 4, 4};
        drain_cnt = '{3, 2, 1, 0};
        m_clear();

        // Reset state
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset.dout", 32'(dout), 0);
        check("reset.dout_vld", 32'(dout_vld), 0);
        check("reset.vld_cnt", 32'(vld_cnt), 0);
        check("reset.full", 32'(full), 0);

        // Latency with dly_sel=2
        step("lat", 1, 0, 8'h11, 1, 2);
        step("lat", 1, 0, 8'h22, 1, 2);
        step("lat", 1, 0, 8'h33, 1, 2);
        check("lat.first", 32'({dout_vld, dout}), 32'h111);
        step("lat", 1, 0, 8'h00, 0, 2);
        check("lat.second", 32'({dout_vld, dout}), 32'h122);
        step("lat", 1, 0, 8'h00, 0, 2);
        check("lat.third", 32'({dout_vld, dout}), 32'h133);

        // Stall with dly_sel=1
        step("stall", 1, 1, 8'h00, 0, 1);
        step("stall", 1, 0, 8'hA5, 1, 1);
        for (int i = 0; i < 5; i++) begin
            step("stall.hold", 0, 0, 8'($urandom), 1'($urandom), 1);
            check("stall.vld_low", 32'(dout_vld), 0);
        end
        step("stall", 1, 0, 8'h00, 0, 1);
        check("stall.emerge", 32'({dout_vld, dout}), 32'h1A5);

        // Fill, full and drain
        step("fill", 1, 1, 8'h00, 0, 3);
        for (int i = 0; i < 6; i++) begin
            step("fill", 1, 0, 8'(8'h40 + i), 1, 3);
            check("fill.cnt", 32'(vld_cnt), CNT_ON ? 32'(fill_cnt[i]) : 0);
            check("fill.full", 32'(full), (CNT_ON && i >= 3) ? 1 : 0);
        end
        check("fill.oldest", 32'({dout_vld, dout}), 32'h142);
        for (int i = 0; i < 4; i++) begin
            step("drain", 1, 0, 8'h00, 0, 3);
            check("drain.cnt", 32'(vld_cnt), CNT_ON ? 32'(drain_cnt[i]) : 0);
        end

        // Flush wins over a valid advance on a full line
        for (int i = 0; i < DEPTH; i++) step("preflush", 1, 0, 8'(8'hC0 + i), 1, 0);
        step("flush", 1, 1, 8'hEE, 1, 0);
        flush = 1'b0;
        en = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            dly_sel = SEL_W'(s);
            #1;
            check("flush.out", 32'({dout_vld, dout}), 0);
            check("flush.cnt", 32'(vld_cnt), 0);
        end

        // Reset mid-stream with three samples in flight
        step("midrst", 1, 0, 8'h71, 1, 3);
        step("midrst", 1, 0, 8'h72, 1, 3);
        step("midrst", 1, 0, 8'h73, 1, 3);
        rst_n = 1'b0;
        step("midrst.edge", 1, 1'b0, 8'h74, 1, 3);
        rst_n = 1'b1;
        check("midrst.out", 32'({dout_vld, dout, vld_cnt, full}), 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step("midrst.after", 1, 0, 8'h00, 0, SEL_W'(i));
            check("midrst.none", 32'(dout_vld), 0);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                 8'($urandom), 1'($urandom), SEL_W'($urandom));
            rst_n = 1'b1;
        end
        #1;
        check_model("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_delay_line.md
PIPE_DELAY_LINE -- requirements
Module: pipe_delay_line

Interface
REQ-001 Parameter WIDTH, default 8, data bits per sample.
REQ-002 Parameter DEPTH, default 4, number of register stages and maximum delay (legal range 2..64).
REQ-003 Parameter SEL_W, default 2, width of dly_sel (SEL_W = clog2(DEPTH)).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  advance strobe; when 1, the pipeline shifts one stage on this edge.
REQ-007 flush  input  1  synchronous clear of all stage valid bits.
REQ-008 din  input  WIDTH  sample into stage 0.
REQ-009 din_vld  input  1  din qualifier.
REQ-010 dly_sel  input  SEL_W  tap select; delay = dly_sel+1 advances.
REQ-011 dout  output  WIDTH  data at the selected tap.
REQ-012 dout_vld  output  1  valid bit at the selected tap.
REQ-013 vld_cnt  output  clog2(DEPTH+1)  number of stages currently holding valid data.
REQ-014 full  output  1  high when vld_cnt == DEPTH.

Function
REQ-015 The block SHALL hold DEPTH stages s[0..DEPTH-1], each with a WIDTH data register and a valid bit.
REQ-016 On a clock edge with en=1 and flush=0, the block SHALL load s[0] <= {din,din_vld} and shift s[k] <= s[k-1] for k=1..DEPTH-1, using non-blocking semantics so that each sample moves exactly one stage per advance.
REQ-017 On a clock edge with en=0 and flush=0, the block SHALL hold every stage unchanged.
REQ-018 dout/dout_vld SHALL be a combinational mux of stage s[min(dly_sel, DEPTH-1)].
REQ-019 A sample accepted on advance N SHALL appear on dout, with dout_vld=1, after advance N+dly_sel, which is dly_sel+1 clock edges later at en=1 continuously.
REQ-020 A dly_sel change SHALL take effect on dout in the same cycle, with no pipeline disturbance; samples skipped or repeated by the change are permitted.
REQ-021 Stages with valid=0 SHALL still shift data; dout may show stale data while dout_vld=0.
REQ-022 When flush=1 on an edge, the block SHALL clear all valid bits and all data registers to 0, regardless of en and din_vld; the incoming sample is discarded (flush wins).
REQ-023 vld_cnt SHALL be a registered counter updated in the same edge as the stages:
  - +1 when the entering valid is 1 and the exiting s[DEPTH-1] valid is 0.
  - -1 when the entering valid is 0 and the exiting valid is 1.
  - Unchanged otherwise, including when en=0.
  - 0 on flush.
REQ-024 vld_cnt SHALL never exceed DEPTH or wrap below 0; at full with continued valid input it SHALL stay at DEPTH, with the oldest sample dropping out of s[DEPTH-1].
REQ-025 full SHALL be combinationally decoded from vld_cnt.

Reset
REQ-026 When rst_n=0 on a clock edge, the block SHALL clear all stage data and valid bits to 0 and set vld_cnt to 0; reset overrides flush and en.
REQ-027 After reset the outputs SHALL be dout=0, dout_vld=0, vld_cnt=0, full=0.
REQ-028 Asserting reset mid-stream SHALL discard all in-flight samples; the first valid output after release is a sample accepted after release.

Configuration
REQ-029 Macro PIPE_DELAY_LINE_CNT_EN SHALL control the occupancy logic.
REQ-030 When PIPE_DELAY_LINE_CNT_EN is defined, the block SHALL implement REQ-023 to REQ-025.
REQ-031 When PIPE_DELAY_LINE_CNT_EN is undefined, no counter SHALL exist; vld_cnt SHALL be tied to 0 and full to 0; the port list is unchanged.

Verification
REQ-032 Latency, WIDTH=8 DEPTH=4: dly_sel=2, en=1, inject 0x11,0x22,0x33 valid on consecutive edges -> dout shows 0x11/vld=1 exactly 3 edges after 0x11 is sampled, then 0x22 and 0x33 on the following cycles.
REQ-033 Stall: inject 0xA5 with dly_sel=1, drop en for 5 cycles after the first advance -> dout_vld stays 0 and nothing moves; 0xA5 appears on the first edge after en returns.
REQ-034 Fill and full (CNT_EN defined): 6 consecutive valid samples at en=1 -> vld_cnt 1,2,3,4,4,4 and full=1 from the 4th edge; then 4 invalid advances -> vld_cnt counts down 3,2,1,0.
REQ-035 Flush: pipeline full with flush=1, en=1, din_vld=1 -> next cycle vld_cnt=0, dout=0, dout_vld=0 for all dly_sel values.
REQ-036 Reset mid-stream: rst_n=0 for 1 edge while 3 samples are in flight -> all outputs 0; none of the 3 samples ever emerges.
REQ-037 Macro off: rerun REQ-034 without PIPE_DELAY_LINE_CNT_EN -> vld_cnt=0 and full=0 throughout, while dout timing is identical.
